// File: rtl/block_residency_table.sv
// Tracks which SD-card blocks are resident in the SRAM slots: single-cycle hit lookup,
// victim selection and a swap handshake with the downstream swap controller on a miss.
module block_residency_table #(
  parameter int NUM_SLOTS = 8,
  parameter int ADDR_W    = 21
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lookup_req_i,
  input  logic [ADDR_W-1:0]            lookup_addr_i,
  input  logic                         lookup_we_i,
  output logic                         lookup_ready_o,
  output logic                         rsp_valid_o,
  output logic [$clog2(NUM_SLOTS)-1:0] rsp_idx_o,
  output logic                         rsp_miss_o,
  output logic                         swap_req_o,
  output logic [$clog2(NUM_SLOTS)-1:0] old_addr_idx_o,
  output logic [ADDR_W-1:0]            old_addr_o,
  output logic [ADDR_W-1:0]            new_addr_o,
  output logic                         block_only_load_on_o,
  input  logic                         done_i,
  output logic [15:0]                  miss_count_o
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                   state, state_nxt;
  logic [NUM_SLOTS-1:0]     valid, dirty;
  logic [ADDR_W-1:0]        tag [NUM_SLOTS];
  logic [IDX_W-1:0]         vptr;
  logic [15:0]              miss_count;

  logic                     hit, free_found;
  logic [IDX_W-1:0]         hit_idx, free_idx, victim_sel;

  logic                     vld_p1;
  logic [IDX_W-1:0]         hit_idx_p1;
  logic [IDX_W-1:0]         vic_idx_p1;
  logic [ADDR_W-1:0]        vic_tag_p1, new_addr_p1;
  logic                     vic_valid_p1, vic_dirty_p1, new_we_p1;

  // Tag compare and victim choice; descending loops let the lowest index win
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == lookup_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    victim_sel = free_found ? free_idx : vptr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (lookup_req_i && !hit) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_i) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Stage p1: hit response register, miss capture and slot refill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid      <= '0;
      dirty      <= '0;
      vptr       <= '0;
      miss_count <= '0;
      vld_p1     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) tag[i] <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (lookup_req_i) begin
            if (hit) begin
              vld_p1     <= 1'b1;
              hit_idx_p1 <= hit_idx;
              if (lookup_we_i) dirty[hit_idx] <= 1'b1;
            end else begin
              vic_idx_p1   <= victim_sel;
              vic_tag_p1   <= tag[victim_sel];
              vic_valid_p1 <= valid[victim_sel];
              vic_dirty_p1 <= dirty[victim_sel];
              new_addr_p1  <= lookup_addr_i;
              new_we_p1    <= lookup_we_i;
              miss_count   <= sat_inc(miss_count);
            end
          end
        end
        WAIT_DONE: begin
          if (done_i) begin
            valid[vic_idx_p1] <= 1'b1;
            dirty[vic_idx_p1] <= new_we_p1;
            tag[vic_idx_p1]   <= new_addr_p1;
            // Only a round-robin eviction advances the pointer; free-slot fills do not
            if (vic_valid_p1) vptr <= vptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic busy;
  assign busy = (state == ISSUE) || (state == WAIT_DONE);

  assign lookup_ready_o       = (state == IDLE);
  assign swap_req_o           = (state == ISSUE);
  assign old_addr_idx_o       = busy ? vic_idx_p1 : '0;
  assign old_addr_o           = (busy && vic_valid_p1) ? vic_tag_p1 : '0;
  assign new_addr_o           = busy ? new_addr_p1 : '0;
  assign block_only_load_on_o = busy && !(vic_valid_p1 && vic_dirty_p1);
  assign rsp_valid_o          = vld_p1 || (state == RESP);
  assign rsp_miss_o           = (state == RESP);
  assign rsp_idx_o            = (state == RESP) ? vic_idx_p1 : (vld_p1 ? hit_idx_p1 : '0);
  assign miss_count_o         = miss_count;
endmodule
